fsm_trace_recorder: RTL and testbench

FSM_TRACE_RECORDER -- requirements
Module: fsm_trace_recorder

---
 rtl/trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 77 +++++++
 rtl/fsm_trace_recorder.sv | 101 ++++++++++
 tb/tb_fsm_trace_recorder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared trace-entry layout for the recorder and the circuit-to-Verilog generator.
// An entry is packed MSB first as {ts, prev_state, new_state, cond}.
package trace_pkg;

  typedef enum logic [1:0] {
    FIELD_TS   = 2'd0,
    FIELD_PREV = 2'd1,
    FIELD_NEW  = 2'd2,
    FIELD_COND = 2'd3
  } trace_field_e;

  localparam int unsigned DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  function automatic int unsigned entry_width(input int unsigned ts_w,
                                              input int unsigned state_w,
                                              input int unsigned cond_w);
    return ts_w + 2 * state_w + cond_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace entries; pointers wrap modulo DEPTH (power of two).
module trace_fifo #(
  parameter int unsigned W     = 14,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Flush wins over any push/pop issued in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push && !pop) begin
        level_d = level_q + (AW+1)'(1);
      end else if (pop && !push) begin
        level_d = level_q - (AW+1)'(1);
      end else begin
        level_d = level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/fsm_trace_recorder.sv
// Records state transitions of an observed FSM as timestamped entries in a FIFO,
// counting events that arrive while the FIFO is full.
module fsm_trace_recorder
  import trace_pkg::*;
#(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned COND_W  = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [STATE_W-1:0]                state_in,
  input  logic [COND_W-1:0]                 cond_in,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [TS_W+2*STATE_W+COND_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              overflow,
  output logic [7:0]                        drop_cnt
);
  localparam int unsigned ENTRY_W = entry_width(TS_W, STATE_W, COND_W);

  logic [STATE_W-1:0]    prev_q, prev_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic               event_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] entry_s;

  assign event_s = enable && (state_in != prev_q);
  assign pop_s   = !empty_s && rd_ready;
  // A full FIFO can still take the event when the head leaves in the same cycle.
  assign push_s  = event_s && !clear && (!full_s || pop_s);
  assign drop_s  = event_s && !clear && full_s && !pop_s;
  assign entry_s = {ts_q, prev_q, state_in, cond_in};

  always_comb begin
    prev_d     = state_in;
    ts_d       = ts_q + TS_W'(1);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (entry_s),
    .rd_data (rd_data),
    .level   (level),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign rd_valid = !empty_s;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fsm_trace_recorder.sv
// Directed bench for fsm_trace_recorder: queue-based reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_fsm_trace_recorder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  state_in = 2'd0;
  logic [1:0]  cond_in = 2'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [13:0] rd_data;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fsm_trace_recorder #(.STATE_W(2), .COND_W(2), .DEPTH(DEPTH), .TS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .state_in(state_in), .cond_in(cond_in), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entries in a queue, plain integer counters.
  logic [13:0] m_q[$];
  int          m_ts = 0;
  int          m_prev = 0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    m_q.delete();
    m_ts = 0;
    m_prev = 0;
    m_ovf = 1'b0;
    m_drop = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit ev;
      bit pop;
      int sz;
      ev  = enable && (int'(state_in) != m_prev);
      sz  = m_q.size();
      pop = (sz != 0) && rd_ready;
      if (clear) begin
        m_q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (ev) begin
          if (sz < DEPTH || pop) begin
            m_q.push_back({8'(m_ts), 2'(m_prev), state_in, cond_in});
          end else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
      m_prev = int'(state_in);
      m_ts = (m_ts + 1) % 256;
    end
  end

  always @(negedge clk) begin
    chk("level", 32'(level), 32'(m_q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step(); step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;                       // this cycle ts=0
    enable = 1'b1;
    state_in = 2'd0;
    step(); step();
    chk("init_state0_no_event", 32'(level), 32'd0);
    step();                             // now ts=3
    state_in = 2'd2; cond_in = 2'd1;
    step();
    chk("first_entry", 32'(rd_data), 32'h00C9);
    chk("first_level", 32'(level), 32'd1);
    chk("first_valid", 32'(rd_valid), 32'd1);

    // replay 00->10->01->00 with rd_ready=1
    state_in = 2'd0; cond_in = 2'd0; enable = 1'b0; rd_ready = 1'b1;
    step();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      state_in = (i == 0) ? 2'd2 : (i == 1) ? 2'd1 : 2'd0;
      cond_in  = (i == 1) ? 2'd3 : 2'd0;
      step();
      chk("replay_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    enable = 1'b0;
    step(); step();
    chk("replay_drained", 32'(level), 32'd0);

    // overflow: 10 transitions into a stalled FIFO
    rd_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      state_in = 2'((i % 3) + 1);
      step();
    end
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);

    // full FIFO, event coincident with pop
    rd_ready = 1'b1; state_in = 2'd2;
    step();
    chk("full_pop_level", 32'(level), 32'd8);
    chk("full_pop_ovf", 32'(overflow), 32'd1);
    chk("full_pop_drop", 32'(drop_cnt), 32'd2);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("drain_level", 32'(level), 32'd0);

    // timestamp wrap
    rd_ready = 1'b0; state_in = 2'd0; cond_in = 2'd2;
    for (int i = 0; i < 300 && m_ts != 254; i++) step();
    if (m_ts != 254) begin
      n_checks++; n_errors++;
      $display("FAIL ts_align: model ts %0d, expected 254", m_ts);
    end
    enable = 1'b1;
    state_in = 2'd1; step();
    state_in = 2'd2; step();
    state_in = 2'd3; step();
    enable = 1'b0;
    chk("wrap_level", 32'(level), 32'd3);
    chk("wrap_e0", 32'(rd_data), 32'h3F86);
    rd_ready = 1'b1;
    step();
    chk("wrap_e1", 32'(rd_data), 32'h3FDA);
    step();
    chk("wrap_e2", 32'(rd_data), 32'h002E);
    rd_ready = 1'b0;

    // clear with an event in the same cycle
    clear = 1'b1; enable = 1'b1; state_in = 2'd0;
    step();
    clear = 1'b0; enable = 1'b0;
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_valid", 32'(rd_valid), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // asynchronous reset mid-drain
    enable = 1'b1;
    state_in = 2'd1; step();
    state_in = 2'd2; step();
    state_in = 2'd3; step();
    enable = 1'b0; rd_ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    rd_ready = 1'b0; enable = 1'b1; cond_in = 2'd1;
    step();
    rst_n = 1'b1;                       // state_in=3 vs prev 0, ts=0
    step();
    enable = 1'b0;
    chk("post_rst_entry", 32'(rd_data), 32'h000D);
    chk("post_rst_level", 32'(level), 32'd1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
